// File: rtl/pc_sequencer.sv
// Program counter and run control for the CSE141L core: IDLE/RUN/HALTED sequencing,
// absolute and signed-relative branches, stall handling and saturating perf counters.
module pc_sequencer #(
  parameter int unsigned    IW       = 8,
  parameter int unsigned    DW       = 8,
  parameter int unsigned    CW       = 16,
  parameter logic [IW-1:0]  START_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_i,
  input  logic          halt_i,
  input  logic          stall_i,
  input  logic          branch_i,
  input  logic          branch_type_i,
  input  logic [IW-1:0] target_i,
  input  logic [DW-1:0] cmp_i,
  output logic [IW-1:0] pc_o,
  output logic          running_o,
  output logic          done_o,
  output logic [CW-1:0] cycle_cnt_o,
  output logic [CW-1:0] instr_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALTED
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] pc_q, pc_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [CW-1:0] ins_q, ins_d;

  logic [CW-1:0] cyc_inc;
  logic [CW-1:0] ins_inc;
  logic          cond_true;

  assign cyc_inc   = (cyc_q == '1) ? cyc_q : cyc_q + CW'(1);
  assign ins_inc   = (ins_q == '1) ? ins_q : ins_q + CW'(1);
  assign cond_true = |cmp_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= START_PC;
      cyc_q   <= '0;
      ins_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cyc_q   <= cyc_d;
      ins_q   <= ins_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cyc_d   = cyc_q;
    ins_d   = ins_q;
    unique case (state_q)
      S_IDLE, S_HALTED: begin
        if (start_i) begin
          state_d = S_RUN;
          pc_d    = START_PC;
          cyc_d   = '0;
          ins_d   = '0;
        end
      end
      S_RUN: begin
        cyc_d = cyc_inc;
        // A stalled cycle retires nothing, so halt/branch/cmp are not looked at.
        if (!stall_i) begin
          ins_d = ins_inc;
          if (halt_i) begin
            state_d = S_HALTED;
          end else if (branch_i && !branch_type_i) begin
            pc_d = target_i;
          end else if (branch_i && branch_type_i && cond_true) begin
            pc_d = pc_q + target_i;
          end else begin
            pc_d = pc_q + IW'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        pc_d    = START_PC;
        cyc_d   = '0;
        ins_d   = '0;
      end
    endcase
  end

  assign pc_o        = pc_q;
  assign running_o   = (state_q == S_RUN);
  assign done_o      = (state_q == S_HALTED);
  assign cycle_cnt_o = cyc_q;
  assign instr_cnt_o = ins_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a behavioural model queues expected outputs per
// clock edge (or async reset) and a monitor pops and compares them.
module tb_pc_sequencer;
  localparam int IW = 8;
  localparam int DW = 8;
  localparam int CW = 4;
  localparam int START = 0;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          reset;
  logic          start_i, halt_i, stall_i, branch_i, branch_type_i;
  logic [IW-1:0] target_i;
  logic [DW-1:0] cmp_i;
  logic [IW-1:0] pc_o;
  logic          running_o, done_o;
  logic [CW-1:0] cycle_cnt_o, instr_cnt_o;

  pc_sequencer #(.IW(IW), .DW(DW), .CW(CW), .START_PC(8'(START))) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .halt_i(halt_i), .stall_i(stall_i),
    .branch_i(branch_i), .branch_type_i(branch_type_i), .target_i(target_i),
    .cmp_i(cmp_i), .pc_o(pc_o), .running_o(running_o), .done_o(done_o),
    .cycle_cnt_o(cycle_cnt_o), .instr_cnt_o(instr_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int pc;
    bit run;
    bit done;
    int cyc;
    int ins;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Model state: run/done flags (neither set means idle), PC and counters as integers.
  int m_pc = START;
  bit m_run = 0;
  bit m_done = 0;
  int m_cyc = 0;
  int m_ins = 0;

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  function automatic void model_reset();
    m_pc = START; m_run = 0; m_done = 0; m_cyc = 0; m_ins = 0;
  endfunction

  function automatic void model_edge(input bit rst, st, hl, sl, br, bt, input int tg, cm);
    int off;
    if (!rst) begin
      model_reset();
    end else if (m_run) begin
      m_cyc = sat(m_cyc + 1);
      if (!sl) begin
        m_ins = sat(m_ins + 1);
        if (hl) begin
          m_run = 0; m_done = 1;
        end else if (br && !bt) begin
          m_pc = tg;
        end else if (br && bt && cm != 0) begin
          off  = (tg >= 128) ? tg - 256 : tg;
          m_pc = (m_pc + off + 256) % 256;
        end else begin
          m_pc = (m_pc + 1) % 256;
        end
      end
    end else if (st) begin
      m_run = 1; m_done = 0; m_pc = START; m_cyc = 0; m_ins = 0;
    end
  endfunction

  function automatic exp_t cur_exp();
    exp_t e;
    e.pc = m_pc; e.run = m_run; e.done = m_done; e.cyc = m_cyc; e.ins = m_ins;
    return e;
  endfunction

  function automatic void check(input string n, input logic [31:0] act, input int req);
    if (act !== 32'(req)) begin
      miscompares++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", n, act, req, $time);
    end
  endfunction

  // Monitor: one expectation per clock edge or asynchronous reset assertion.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or negedge reset);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        check("pc", 32'(pc_o), e.pc);
        check("running", 32'(running_o), int'(e.run));
        check("done", 32'(done_o), int'(e.done));
        check("cycle_cnt", 32'(cycle_cnt_o), e.cyc);
        check("instr_cnt", 32'(instr_cnt_o), e.ins);
      end
    end
  end

  task automatic step(input bit rst, st, hl, sl, br, bt, input int tg, cm);
    @(negedge clk);
    reset = rst; start_i = st; halt_i = hl; stall_i = sl;
    branch_i = br; branch_type_i = bt; target_i = 8'(tg); cmp_i = 8'(cm);
    model_edge(rst, st, hl, sl, br, bt, tg, cm);
    exp_q.push_back(cur_exp());
  endtask

  task automatic plain(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic run_to(input int pc);
    int n = 0;
    while (m_pc != pc && n < 300) begin
      step(1, 0, 0, 0, 0, 0, 0, 0);
      n++;
    end
    if (m_pc != pc) begin
      miscompares++;
      $display("FAIL run_to: reached %0d required %0d", m_pc, pc);
    end
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    reset = 1'b0;
    model_reset();
    exp_q.push_back(cur_exp());
  endtask

  initial begin
    int r;
    reset = 0; start_i = 0; halt_i = 0; stall_i = 0;
    branch_i = 0; branch_type_i = 0; target_i = '0; cmp_i = '0;

    // Reset and start, then sequential fetch.
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    plain(3);

    // Absolute branch, taken and not-taken relative branch.
    run_to(5);
    step(1, 0, 0, 0, 1, 0, 8'h40, 0);
    step(1, 0, 0, 0, 1, 1, 8'hFC, 1);
    run_to(8'h40);
    step(1, 0, 0, 0, 1, 1, 8'hFC, 0);

    // Wrap, then stalled halt.
    run_to(8'hFF);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    run_to(3);
    repeat (4) step(1, 0, 1, 1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0, 0);
    plain(2);

    // Restart, halt at 7 after 7 retired, hold, restart.
    step(1, 1, 0, 0, 0, 0, 0, 0);
    run_to(7);
    step(1, 0, 1, 0, 0, 0, 0, 0);
    plain(10);
    step(1, 1, 0, 0, 0, 0, 0, 0);

    // Start held through RUN, counters saturate; then reset mid-stall.
    repeat (20) step(1, 1, 0, 0, 0, 0, 0, 0);
    repeat (2) step(1, 0, 0, 1, 0, 0, 0, 0);
    async_reset();
    repeat (2) step(0, 0, 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);

    // Minimum program: halt at START_PC.
    step(1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0, 0);

    // Randomised traffic with occasional asynchronous resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        async_reset();
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
      end else begin
        r = $urandom_range(0, 1);
        step(1, ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
             bit'(r), int'($urandom_range(0, 255)),
             ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 255)));
      end
    end

    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
